// File: rtl/drop_engine_if.sv
// rtl/drop_engine_if.sv - button/control inputs and board/status outputs of the drop engine
interface drop_engine_if #(
    parameter int ROWS = 6,
    parameter int COLS = 7
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                       left;
    logic                       right;
    logic                       confirm;
    logic                       currentPlayer;
    logic                       clear;
    logic [COLS-1:0]            ledPosition;
    logic [CW-1:0]              cursorCol;
    logic [ROWS-1:0][COLS-1:0]  board0;
    logic [ROWS-1:0][COLS-1:0]  board1;
    logic                       busy;
    logic [RW-1:0]              fallRow;
    logic                       dropDone;
    logic [RW-1:0]              dropRow;
    logic [CW-1:0]              dropCol;
    logic                       illegal;
    logic                       boardFull;

    modport master (
        output left, right, confirm, currentPlayer, clear,
        input  ledPosition, cursorCol, board0, board1, busy, fallRow,
               dropDone, dropRow, dropCol, illegal, boardFull
    );

    modport slave (
        input  left, right, confirm, currentPlayer, clear,
        output ledPosition, cursorCol, board0, board1, busy, fallRow,
               dropDone, dropRow, dropCol, illegal, boardFull
    );
endinterface

// File: rtl/drop_engine.sv
// rtl/drop_engine.sv - cursor control, legality check, timed piece fall and two-plane board storage
module drop_engine #(
    parameter int ROWS       = 6,
    parameter int COLS       = 7,
    parameter int FALL_TICKS = 1,
    parameter int WRAP       = 0
) (
    input  logic          clk,
    input  logic          reset,
    drop_engine_if.slave  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, FALL, DONE} state_t;

    state_t                    state, state_nx;
    logic                      left_q, right_q, confirm_q;
    logic                      left_p, right_p, confirm_p;
    logic [CW-1:0]             cursor, cursor_nx;
    logic [RW-1:0]             fall_row, fall_row_nx;
    logic [RW-1:0]             below_row;
    logic [TW-1:0]             tick, tick_nx;
    logic [CW-1:0]             col, col_nx;
    logic                      player, player_nx;
    logic [ROWS-1:0][COLS-1:0] board0, board0_nx;
    logic [ROWS-1:0][COLS-1:0] board1, board1_nx;
    logic [ROWS-1:0][COLS-1:0] occ;
    logic [RW-1:0]             drop_row, drop_row_nx;
    logic [CW-1:0]             drop_col, drop_col_nx;
    logic                      illegal, illegal_nx;

    assign left_p    = bus.left    & ~left_q;
    assign right_p   = bus.right   & ~right_q;
    assign confirm_p = bus.confirm & ~confirm_q;
    assign occ       = board0 | board1;

    // Previous-sample history for the button edge detectors
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            confirm_q <= 1'b0;
        end else begin
            left_q    <= bus.left;
            right_q   <= bus.right;
            confirm_q <= bus.confirm;
        end
    end

    // State, cursor, fall position and board registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cursor   <= CW'(COLS / 2);
            fall_row <= '0;
            tick     <= '0;
            col      <= '0;
            player   <= 1'b0;
            board0   <= '0;
            board1   <= '0;
            drop_row <= '0;
            drop_col <= '0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nx;
            cursor   <= cursor_nx;
            fall_row <= fall_row_nx;
            tick     <= tick_nx;
            col      <= col_nx;
            player   <= player_nx;
            board0   <= board0_nx;
            board1   <= board1_nx;
            drop_row <= drop_row_nx;
            drop_col <= drop_col_nx;
            illegal  <= illegal_nx;
        end
    end

    // Next-state: clear wins everywhere; button edges only act in IDLE
    always_comb begin
        state_nx    = state;
        cursor_nx   = cursor;
        fall_row_nx = fall_row;
        tick_nx     = tick;
        col_nx      = col;
        player_nx   = player;
        board0_nx   = board0;
        board1_nx   = board1;
        drop_row_nx = drop_row;
        drop_col_nx = drop_col;
        illegal_nx  = 1'b0;
        // Row below the piece; clamped at the bottom so the index stays in range
        below_row   = (fall_row == RW'(ROWS - 1)) ? fall_row : fall_row + RW'(1);
        if (bus.clear) begin
            board0_nx   = '0;
            board1_nx   = '0;
            state_nx    = IDLE;
            fall_row_nx = '0;
            tick_nx     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (left_p && !right_p) begin
                        if (cursor == CW'(0))
                            cursor_nx = (WRAP != 0) ? CW'(COLS - 1) : CW'(0);
                        else
                            cursor_nx = cursor - CW'(1);
                    end else if (right_p && !left_p) begin
                        if (cursor == CW'(COLS - 1))
                            cursor_nx = (WRAP != 0) ? CW'(0) : CW'(COLS - 1);
                        else
                            cursor_nx = cursor + CW'(1);
                    end
                    // The drop column is the cursor before any same-cycle move
                    if (confirm_p) begin
                        if (occ[0][cursor]) begin
                            illegal_nx = 1'b1;
                        end else begin
                            col_nx      = cursor;
                            player_nx   = bus.currentPlayer;
                            fall_row_nx = '0;
                            tick_nx     = '0;
                            state_nx    = FALL;
                        end
                    end
                end
                FALL: begin
                    if (tick == TW'(FALL_TICKS - 1)) begin
                        tick_nx = '0;
                        if (fall_row == RW'(ROWS - 1) || occ[below_row][col]) begin
                            if (player)
                                board1_nx[fall_row][col] = 1'b1;
                            else
                                board0_nx[fall_row][col] = 1'b1;
                            drop_row_nx = fall_row;
                            drop_col_nx = col;
                            state_nx    = DONE;
                        end else begin
                            fall_row_nx = fall_row + RW'(1);
                        end
                    end else begin
                        tick_nx = tick + TW'(1);
                    end
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.ledPosition = COLS'(1) << cursor;
    assign bus.cursorCol   = cursor;
    assign bus.board0      = board0;
    assign bus.board1      = board1;
    assign bus.busy        = (state == FALL);
    assign bus.fallRow     = fall_row;
    assign bus.dropDone    = (state == DONE);
    assign bus.dropRow     = drop_row;
    assign bus.dropCol     = drop_col;
    assign bus.illegal     = illegal;
    assign bus.boardFull   = &occ[0];
endmodule

// File: tb/tb_drop_engine.sv
// tb/tb_drop_engine.sv - scoreboard bench for drop_engine (FALL_TICKS=1/WRAP=0 and FALL_TICKS=4/WRAP=1)
module tb_drop_engine;
    typedef struct {
        bit ill;
        int row;
        int col;
        bit pl;
    } exp_t;

    logic clk;
    logic reset;

    drop_engine_if #(.ROWS(6), .COLS(7)) ia ();
    drop_engine_if #(.ROWS(6), .COLS(7)) ib ();

    drop_engine #(.ROWS(6), .COLS(7), .FALL_TICKS(1), .WRAP(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ia)
    );
    drop_engine #(.ROWS(6), .COLS(7), .FALL_TICKS(4), .WRAP(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ib)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [41:0] mb0[2];
    logic [41:0] mb1[2];
    int          height[2][7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit (passed %0d of %0d)", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input int d, input int s, input logic v);
        if (d == 0) begin
            case (s)
                0: ia.left = v;
                1: ia.right = v;
                2: ia.confirm = v;
                3: ia.clear = v;
                default: ia.currentPlayer = v;
            endcase
        end else begin
            case (s)
                0: ib.left = v;
                1: ib.right = v;
                2: ib.confirm = v;
                3: ib.clear = v;
                default: ib.currentPlayer = v;
            endcase
        end
    endtask

    task automatic pulse(input int d, input int s);
        @(negedge clk) drive(d, s, 1'b1);
        @(negedge clk) drive(d, s, 1'b0);
    endtask

    function automatic int cur(input int d);
        return (d == 0) ? int'(ia.cursorCol) : int'(ib.cursorCol);
    endfunction

    function automatic logic [41:0] pb(input int d, input bit p);
        if (d == 0) return p ? ia.board1 : ia.board0;
        return p ? ib.board1 : ib.board0;
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic model_set(input int d, input bit p, input int r, input int c);
        if (p) mb1[d][r*7+c] = 1'b1;
        else   mb0[d][r*7+c] = 1'b1;
        height[d][c]++;
    endtask

    task automatic chk_boards(input int d, input string tag);
        chk({tag, "_board0"}, pb(d, 1'b0), mb0[d]);
        chk({tag, "_board1"}, pb(d, 1'b1), mb1[d]);
    endtask

    task automatic do_drop(input int d, input bit p, input int r, input int c);
        exp_t e;
        e = '{1'b0, r, c, p};
        drive(d, 4, p);
        push_exp(d, e);
        pulse(d, 2);
        repeat (6 * ((d == 0) ? 1 : 4) + 3) @(negedge clk);
        model_set(d, p, r, c);
        chk_boards(d, "drop");
    endtask

    task automatic move_to(input int d, input int target);
        for (int i = 0; i < 16; i++) begin
            if (cur(d) == target) break;
            if (cur(d) < target) pulse(d, 1);
            else pulse(d, 0);
        end
        chk("move_to", cur(d), target);
    endtask

    task automatic mon(input int d);
        logic dd, il;
        int dr, dc, idx;
        exp_t e;
        bit empty;
        if (d == 0) begin
            dd = ia.dropDone; il = ia.illegal; dr = int'(ia.dropRow); dc = int'(ia.dropCol);
            empty = (qa.size() == 0);
        end else begin
            dd = ib.dropDone; il = ib.illegal; dr = int'(ib.dropRow); dc = int'(ib.dropCol);
            empty = (qb.size() == 0);
        end
        if (dd || il) begin
            if (empty) begin
                chk("unexpected_output", {dd, il}, 2'b00);
            end else begin
                if (d == 0) e = qa.pop_front();
                else e = qb.pop_front();
                chk("kind_illegal", il, e.ill);
                chk("kind_done", dd, !e.ill);
                if (!e.ill) begin
                    idx = e.row * 7 + e.col;
                    chk("drop_row", dr, e.row);
                    chk("drop_col", dc, e.col);
                    chk("plane_set", pb(d, e.pl)[idx], 1'b1);
                    chk("other_plane_clear", pb(d, !e.pl)[idx], 1'b0);
                end
            end
        end
    endtask

    // Scoreboard monitor: pops one expectation per dropDone/illegal pulse
    always @(negedge clk) begin
        if (mon_en) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        exp_t e;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 5; s++) drive(d, s, 1'b0);
            mb0[d] = '0;
            mb1[d] = '0;
            for (int c = 0; c < 7; c++) height[d][c] = 0;
        end
        repeat (3) @(negedge clk);

        chk("rst_cursor_a", ia.cursorCol, 3);
        chk("rst_led_a", ia.ledPosition, 7'b0001000);
        chk("rst_cursor_b", ib.cursorCol, 3);
        chk("rst_boards_a", {ia.board0, ia.board1}, 84'd0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_fallrow", ia.fallRow, 0);
        chk("rst_droprow", ia.dropRow, 0);
        chk("rst_dropcol", ia.dropCol, 0);
        chk("rst_done", ia.dropDone, 0);
        chk("rst_illegal", ia.illegal, 0);
        chk("rst_full", ia.boardFull, 0);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single drop into an empty column, FALL_TICKS=1
        drive(0, 4, 1'b0);
        e = '{1'b0, 5, 3, 1'b0};
        push_exp(0, e);
        pulse(0, 2);
        for (int k = 0; k < 6; k++) begin
            chk("t1_busy", ia.busy, 1);
            chk("t1_fallrow", ia.fallRow, k);
            chk("t1_not_landed", ia.board0[5][3], 0);
            @(negedge clk);
        end
        chk("t1_busy_off", ia.busy, 0);
        chk("t1_landed", ia.board0[5][3], 1);
        chk("t1_done", ia.dropDone, 1);
        repeat (3) @(negedge clk);
        chk("t1_done_once", ia.dropDone, 0);
        model_set(0, 1'b0, 5, 3);

        // Fill column 3, then a rejected drop
        for (int i = 1; i < 6; i++) do_drop(0, bit'(i % 2), 5 - i, 3);
        e = '{1'b1, 0, 3, 1'b0};
        push_exp(0, e);
        pulse(0, 2);
        chk("t2_no_busy", ia.busy, 0);
        repeat (3) @(negedge clk);
        chk_boards(0, "t2_unchanged");

        // Cursor movement, saturating
        @(negedge clk) begin drive(0, 0, 1'b1); drive(0, 1, 1'b1); end
        @(negedge clk) begin drive(0, 0, 1'b0); drive(0, 1, 1'b0); end
        chk("t3_both_no_move", ia.cursorCol, 3);
        repeat (5) pulse(0, 0);
        chk("t3_sat_left", ia.cursorCol, 0);
        chk("t3_led_left", ia.ledPosition, 7'b0000001);
        repeat (8) pulse(0, 1);
        chk("t3_sat_right", ia.cursorCol, 6);
        chk("t3_led_right", ia.ledPosition, 7'b1000000);

        // Clear during a fall aborts the drop
        drive(0, 4, 1'b1);
        pulse(0, 2);
        @(negedge clk);
        chk("t5_busy_before", ia.busy, 1);
        drive(0, 3, 1'b1);
        @(negedge clk) drive(0, 3, 1'b0);
        chk("t5_busy_cleared", ia.busy, 0);
        chk("t5_boards_zero", {ia.board0, ia.board1}, 84'd0);
        mb0[0] = '0;
        mb1[0] = '0;
        for (int c = 0; c < 7; c++) height[0][c] = 0;
        repeat (10) @(negedge clk);
        chk("t5_still_zero", {ia.board0, ia.board1}, 84'd0);
        chk("t5_cursor_kept", ia.cursorCol, 6);
        do_drop(0, 1'b0, 5, 6);

        // Fill the whole board, then every column is rejected
        for (int c = 0; c < 7; c++) begin
            move_to(0, c);
            while (height[0][c] < 6) do_drop(0, bit'((height[0][c] + c) % 2), 5 - height[0][c], c);
        end
        chk("t6_full", ia.boardFull, 1);
        chk("t6_disjoint", ia.board0 & ia.board1, 42'd0);
        for (int c = 6; c >= 0; c--) begin
            move_to(0, c);
            e = '{1'b1, 0, c, 1'b0};
            push_exp(0, e);
            pulse(0, 2);
            repeat (2) @(negedge clk);
        end
        chk_boards(0, "t6_unchanged");

        // Wrapping cursor on the FALL_TICKS=4 instance
        repeat (3) pulse(1, 0);
        chk("t3w_at_zero", ib.cursorCol, 0);
        pulse(1, 0);
        chk("t3w_wrap_left", ib.cursorCol, 6);
        chk("t3w_led", ib.ledPosition, 7'b1000000);
        pulse(1, 1);
        chk("t3w_wrap_right", ib.cursorCol, 0);

        // Timed fall onto a two-high stack; button edges during the fall are ignored
        do_drop(1, 1'b1, 5, 0);
        do_drop(1, 1'b0, 4, 0);
        drive(1, 4, 1'b1);
        e = '{1'b0, 3, 0, 1'b1};
        push_exp(1, e);
        pulse(1, 2);
        pulse(1, 0);
        pulse(1, 2);
        repeat (11) @(negedge clk);
        chk("t4_busy", ib.busy, 1);
        chk("t4_not_yet", ib.board1[3][0], 0);
        @(negedge clk);
        chk("t4_landed", ib.board1[3][0], 1);
        chk("t4_done", ib.dropDone, 1);
        repeat (12) @(negedge clk);
        model_set(1, 1'b1, 3, 0);
        chk("t4_cursor_kept", ib.cursorCol, 0);
        chk_boards(1, "t4_single_piece");

        repeat (5) @(negedge clk);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
